unidade_controle_rodadas: RTL
=============================

// Module: unidade_controle_rodadas
// PURPOSE
//  Moore FSM that sequences the 16-round memory-game datapath (ROM, address/round counters, play register,
//  comparator, timeout timer). Each round: replay stored sequence on leds up to current limit, collect and
//  check player moves, then advance round or end in hit/miss/timeout. Top-level instantiates it beside the datapath.
// PARAMETERS
//  MOSTRA_CICLOS  500  clock cycles each sequence LED stays lit during replay (>=1)
//  APAGA_CICLOS   250  clock cycles LEDs stay dark between replayed items (>=1)
// PORTS
//  clock        in   1  system clock
//  reset        in   1  synchronous, active-high
//  jogar        in   1  start/restart request (level, sampled each clock)
//  fimE         in   1  address counter == current round limit
//  fimR         in   1  round counter at last round (15)
//  jogada       in   1  one-cycle pulse: new move detected on chaves
//  igual        in   1  comparator: registered move == ROM data
//  timeout      in   1  datapath timeout counter expired
//  zeraE,contaE out  1  clear / increment address counter
//  zeraR,contaR out  1  clear / increment round counter
//  registraR    out  1  load play register from chaves
//  zeraT,contaT out  1  clear / enable timeout counter
//  mostra_leds  out  1  leds mux selects ROM data (replay)
//  pronto       out  1  game finished
//  acertou      out  1  finished, all 16 rounds correct
//  errou        out  1  finished, wrong move or timeout
//  db_timeout   out  1  finished by timeout
//  db_estado    out  4  current state code (to 7-seg)
// BEHAVIOUR
//  Registered state + internal replay timer; all outputs decoded from state only (Moore). Reset -> inicial, timer 0, all outputs 0.
//  States/transitions (db_estado hex; outputs asserted):
//   0 inicial: none. jogar -> 1
//   1 preparacao: zeraE,zeraR,zeraT -> 2
//   2 inicia_rodada: zeraE,zeraT -> 3
//   3 mostra_led: mostra_leds; after exactly MOSTRA_CICLOS cycles -> 4
//   4 apaga_led: after exactly APAGA_CICLOS cycles: fimE -> 6, else -> 5
//   5 proximo_led: contaE -> 3
//   6 fim_mostra: zeraE,zeraT -> 7
//   7 espera_jogada: contaT. jogada -> 8; else timeout -> E
//   8 registra: registraR,zeraT -> 9
//   9 comparacao: !igual -> D; igual&!fimE -> A; igual&fimE&!fimR -> B; igual&fimE&fimR -> C
//   A proxima_jogada: contaE -> 7
//   B proxima_rodada: contaR -> 2
//   C fim_acertou: pronto,acertou | D fim_errou: pronto,errou | E fim_timeout: pronto,errou,db_timeout
//   C/D/E hold until jogar -> 1 (restart, no reset needed)
//  Timer: cleared on every state change; counts only in 3/4; terminal count MOSTRA_CICLOS-1 / APAGA_CICLOS-1;
//   width $clog2(max(MOSTRA_CICLOS,APAGA_CICLOS))+1 bits.
//  Boundaries: jogada and timeout same cycle in 7 -> jogada wins (8). jogar ignored outside 0/C/D/E.
//   jogada pulses outside 7 ignored. Reset mid-game -> inicial on next edge, timer cleared, outputs 0.
//   Unused codes (F, and E without macro) -> inicial next cycle. Each control pulse lasts exactly one cycle.
// CONFIGURATION
//  CONTROLE_TIMEOUT_EN defined: behaviour as above (timeout honoured in 7, state E reachable).
//  Not defined: timeout input ignored; zeraT, contaT, db_timeout tied 0; 7 waits for jogada indefinitely.
// STRUCTURE
//  Shared package/include jogo_pkg: 4-bit state code localparams (0..E above), N_RODADAS=16, default timing constants.
//  One sub-module: temporizador_mostra (param'd cycle counter, inputs zera/conta, output fim) used for 3/4 dwell.
// TESTING (bench uses MOSTRA_CICLOS=4, APAGA_CICLOS=2)
//  Reset 3 cycles, jogar 1 cycle -> db_estado 0,1,2,3; zeraE,zeraR,zeraT high exactly in cycle of state 1.
//  Round 1 replay, fimE=1 -> mostra_leds high exactly 4 cycles, low 2, then states 6,7; contaE never pulsed.
//  Round 2 replay, fimE=0 then 1 -> sequence 3,4,5,3,4,6; single contaE pulse in state 5.
//  In 7 pulse jogada, igual=1,fimE=1,fimR=0 -> 8,9,B,2; one-cycle contaR; registraR high only in 8.
//  igual=0 at 9 -> D, pronto=1,errou=1 held 20 cycles; jogar=1 -> 1. With macro: timeout=1 in 7 -> E,
//   db_timeout=1; jogada+timeout same cycle -> 8. Without macro: timeout=1 in 7 -> stays 7.
//  Full 16 rounds with fimR=1 on last -> C, acertou=1, errou=0; reset mid-replay (state 3) -> 0, outputs 0.

Source files
------------

// File: rtl/jogo_pkg.sv
// Shared definitions for the memory-game control unit: state codes, game size and default timing.
package jogo_pkg;

    localparam logic [3:0] E_INICIAL        = 4'h0;
    localparam logic [3:0] E_PREPARACAO     = 4'h1;
    localparam logic [3:0] E_INICIA_RODADA  = 4'h2;
    localparam logic [3:0] E_MOSTRA_LED     = 4'h3;
    localparam logic [3:0] E_APAGA_LED      = 4'h4;
    localparam logic [3:0] E_PROXIMO_LED    = 4'h5;
    localparam logic [3:0] E_FIM_MOSTRA     = 4'h6;
    localparam logic [3:0] E_ESPERA_JOGADA  = 4'h7;
    localparam logic [3:0] E_REGISTRA       = 4'h8;
    localparam logic [3:0] E_COMPARACAO     = 4'h9;
    localparam logic [3:0] E_PROXIMA_JOGADA = 4'hA;
    localparam logic [3:0] E_PROXIMA_RODADA = 4'hB;
    localparam logic [3:0] E_FIM_ACERTOU    = 4'hC;
    localparam logic [3:0] E_FIM_ERROU      = 4'hD;
    localparam logic [3:0] E_FIM_TIMEOUT    = 4'hE;

    localparam int N_RODADAS             = 16;
    localparam int MOSTRA_CICLOS_PADRAO  = 500;
    localparam int APAGA_CICLOS_PADRAO   = 250;

    typedef enum logic [3:0] {
        INICIAL        = E_INICIAL,
        PREPARACAO     = E_PREPARACAO,
        INICIA_RODADA  = E_INICIA_RODADA,
        MOSTRA_LED     = E_MOSTRA_LED,
        APAGA_LED      = E_APAGA_LED,
        PROXIMO_LED    = E_PROXIMO_LED,
        FIM_MOSTRA     = E_FIM_MOSTRA,
        ESPERA_JOGADA  = E_ESPERA_JOGADA,
        REGISTRA       = E_REGISTRA,
        COMPARACAO     = E_COMPARACAO,
        PROXIMA_JOGADA = E_PROXIMA_JOGADA,
        PROXIMA_RODADA = E_PROXIMA_RODADA,
        FIM_ACERTOU    = E_FIM_ACERTOU,
        FIM_ERROU      = E_FIM_ERROU,
        FIM_TIMEOUT    = E_FIM_TIMEOUT
    } estado_t;

    function automatic int maximo(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/unidade_controle_rodadas_temporizador.sv
// Dwell counter for the replay states: cleared by zera, advances while conta, fim at the terminal count.
module temporizador_mostra #(
    parameter int LARGURA = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               zera,
    input  logic               conta,
    input  logic [LARGURA-1:0] limite,
    output logic               fim
);

    logic [LARGURA-1:0] contagem_reg;

    always_ff @(posedge clock) begin
        if (reset || zera) begin
            contagem_reg <= '0;
        end else if (conta) begin
            contagem_reg <= contagem_reg + 1'b1;
        end
    end

    assign fim = conta && (contagem_reg == limite);

endmodule

// File: rtl/unidade_controle_rodadas.sv
// Moore control FSM for the 16-round memory game; optional timeout handling under CONTROLE_TIMEOUT_EN.
module unidade_controle_rodadas
    import jogo_pkg::*;
#(
    parameter int MOSTRA_CICLOS = MOSTRA_CICLOS_PADRAO,
    parameter int APAGA_CICLOS  = APAGA_CICLOS_PADRAO
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       jogar,
    input  logic       fimE,
    input  logic       fimR,
    input  logic       jogada,
    input  logic       igual,
    input  logic       timeout,
    output logic       zeraE,
    output logic       contaE,
    output logic       zeraR,
    output logic       contaR,
    output logic       registraR,
    output logic       zeraT,
    output logic       contaT,
    output logic       mostra_leds,
    output logic       pronto,
    output logic       acertou,
    output logic       errou,
    output logic       db_timeout,
    output logic [3:0] db_estado
);

    localparam int LARGURA = $clog2(maximo(MOSTRA_CICLOS, APAGA_CICLOS)) + 1;
    localparam logic [LARGURA-1:0] LIMITE_MOSTRA = LARGURA'(MOSTRA_CICLOS - 1);
    localparam logic [LARGURA-1:0] LIMITE_APAGA  = LARGURA'(APAGA_CICLOS - 1);

    estado_t estado_reg, estado_next;
    logic    fim_tempo;
    logic    timeout_valido;

`ifdef CONTROLE_TIMEOUT_EN
    assign timeout_valido = timeout;
`else
    logic timeout_unused;
    assign timeout_unused = timeout;
    assign timeout_valido = 1'b0;
`endif

    // The dwell timer restarts on every state change, so each replay state starts at zero.
    temporizador_mostra #(.LARGURA(LARGURA)) u_temporizador (
        .clock  (clock),
        .reset  (reset),
        .zera   (estado_next != estado_reg),
        .conta  ((estado_reg == MOSTRA_LED) || (estado_reg == APAGA_LED)),
        .limite ((estado_reg == APAGA_LED) ? LIMITE_APAGA : LIMITE_MOSTRA),
        .fim    (fim_tempo)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_reg <= INICIAL;
        end else begin
            estado_reg <= estado_next;
        end
    end

    always_comb begin
        estado_next = estado_reg;
        case (estado_reg)
            INICIAL:        if (jogar) estado_next = PREPARACAO;
            PREPARACAO:     estado_next = INICIA_RODADA;
            INICIA_RODADA:  estado_next = MOSTRA_LED;
            MOSTRA_LED:     if (fim_tempo) estado_next = APAGA_LED;
            APAGA_LED:      if (fim_tempo) estado_next = fimE ? FIM_MOSTRA : PROXIMO_LED;
            PROXIMO_LED:    estado_next = MOSTRA_LED;
            FIM_MOSTRA:     estado_next = ESPERA_JOGADA;
            ESPERA_JOGADA: begin
                if (jogada) begin
                    estado_next = REGISTRA;
                end else if (timeout_valido) begin
                    estado_next = FIM_TIMEOUT;
                end
            end
            REGISTRA:       estado_next = COMPARACAO;
            COMPARACAO: begin
                if (!igual)      estado_next = FIM_ERROU;
                else if (!fimE)  estado_next = PROXIMA_JOGADA;
                else if (!fimR)  estado_next = PROXIMA_RODADA;
                else             estado_next = FIM_ACERTOU;
            end
            PROXIMA_JOGADA: estado_next = ESPERA_JOGADA;
            PROXIMA_RODADA: estado_next = INICIA_RODADA;
            FIM_ACERTOU,
            FIM_ERROU:      if (jogar) estado_next = PREPARACAO;
`ifdef CONTROLE_TIMEOUT_EN
            FIM_TIMEOUT:    if (jogar) estado_next = PREPARACAO;
`endif
            default:        estado_next = INICIAL;
        endcase
    end

    always_comb begin
        zeraE       = 1'b0;
        contaE      = 1'b0;
        zeraR       = 1'b0;
        contaR      = 1'b0;
        registraR   = 1'b0;
        zeraT       = 1'b0;
        contaT      = 1'b0;
        mostra_leds = 1'b0;
        pronto      = 1'b0;
        acertou     = 1'b0;
        errou       = 1'b0;
        db_timeout  = 1'b0;
        case (estado_reg)
            PREPARACAO:     begin zeraE = 1'b1; zeraR = 1'b1; zeraT = 1'b1; end
            INICIA_RODADA:  begin zeraE = 1'b1; zeraT = 1'b1; end
            MOSTRA_LED:     mostra_leds = 1'b1;
            PROXIMO_LED:    contaE = 1'b1;
            FIM_MOSTRA:     begin zeraE = 1'b1; zeraT = 1'b1; end
            ESPERA_JOGADA:  contaT = 1'b1;
            REGISTRA:       begin registraR = 1'b1; zeraT = 1'b1; end
            PROXIMA_JOGADA: contaE = 1'b1;
            PROXIMA_RODADA: contaR = 1'b1;
            FIM_ACERTOU:    begin pronto = 1'b1; acertou = 1'b1; end
            FIM_ERROU:      begin pronto = 1'b1; errou = 1'b1; end
            FIM_TIMEOUT:    begin pronto = 1'b1; errou = 1'b1; db_timeout = 1'b1; end
            default:        ;
        endcase
`ifndef CONTROLE_TIMEOUT_EN
        zeraT      = 1'b0;
        contaT     = 1'b0;
        db_timeout = 1'b0;
`endif
    end

    assign db_estado = estado_reg;

endmodule
